// File: rtl/wb_port_scheduler_pkg.sv
// Shared constants and helpers for the uDLX register-file write-back scheduler.
// Defaults match the uDLX register bank geometry.
package wb_port_scheduler_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int R0_INDEX          = 0;

    // Circular successor of idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Write-back request bus and register-file write ports of the scheduler.
// master = producers/pipeline side, slave = scheduler side.
interface wb_port_scheduler_if
    import wb_port_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);

    logic                               hold;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]      req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               pending;

    logic                               reg_a_wr_en;
    logic [ADDRESS_WIDTH-1:0]           reg_a_wr_addr;
    logic [DATA_WIDTH-1:0]              reg_a_wr_data;
    logic                               reg_b_wr_en;
    logic [ADDRESS_WIDTH-1:0]           reg_b_wr_addr;
    logic [DATA_WIDTH-1:0]              reg_b_wr_data;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, pending,
        input  reg_a_wr_en, reg_a_wr_addr, reg_a_wr_data,
        input  reg_b_wr_en, reg_b_wr_addr, reg_b_wr_data
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, pending,
        output reg_a_wr_en, reg_a_wr_addr, reg_a_wr_data,
        output reg_b_wr_en, reg_b_wr_addr, reg_b_wr_data
    );

endinterface

// File: rtl/wb_rr_picker.sv
// Circular priority picker: first set bit of mask at or after start, wrapping.
// Purely combinational; used for both the round-robin and the urgent (start=0) passes.
module wb_rr_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : scan
        int pos;
        // NOTE: every always_comb output gets a default before any branch; a path
        // that leaves one unassigned would infer a latch.
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!found && mask[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Dual-port write-back scheduler for the uDLX register file: round-robin with aging,
// never two writes to one address per cycle, registered outputs into register_bank.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int MAX_WAIT      = 7,
    parameter bit R0_DISCARD    = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    wb_port_scheduler_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]    data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]       drop, cand, urgent, mask_b, urgent_b, ready;

    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0]        wait_q [NUM_REQ];
    logic [WAIT_W-1:0]        wait_d [NUM_REQ];

    logic                     a_en_q, a_en_d, b_en_q, b_en_d;
    logic [ADDRESS_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [DATA_WIDTH-1:0]    a_data_q, a_data_d, b_data_q, b_data_d;

    logic                     urg_a_found, rr_a_found, urg_b_found, rr_b_found;
    logic [IDX_W-1:0]         urg_a_idx, rr_a_idx, urg_b_idx, rr_b_idx;
    logic                     a_found, b_found;
    logic [IDX_W-1:0]         a_idx, b_idx, last_idx;
    logic [ADDRESS_WIDTH-1:0] a_sel_addr;

    // R0 drops are acknowledged without ever competing for a port.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            drop[i]     = R0_DISCARD && bus.req_valid[i]
                          && (addr_arr[i] == ADDRESS_WIDTH'(R0_INDEX));
            cand[i]     = bus.req_valid[i] && !drop[i];
            urgent[i]   = cand[i] && (wait_q[i] == WAIT_SAT);
        end
    end

    wb_rr_picker #(.N(NUM_REQ)) u_pick_a_urg (
        .mask (urgent), .start ('0), .found (urg_a_found), .idx (urg_a_idx)
    );

    wb_rr_picker #(.N(NUM_REQ)) u_pick_a_rr (
        .mask (cand), .start (rr_ptr_q), .found (rr_a_found), .idx (rr_a_idx)
    );

    assign a_found    = urg_a_found | rr_a_found;
    assign a_idx      = urg_a_found ? urg_a_idx : rr_a_idx;
    assign a_sel_addr = addr_arr[a_idx];

    // Port B excludes A's winner and everything targeting A's address.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_b[i]   = a_found && cand[i] && (a_idx != IDX_W'(i))
                          && (addr_arr[i] != a_sel_addr);
            urgent_b[i] = mask_b[i] && urgent[i];
        end
    end

    wb_rr_picker #(.N(NUM_REQ)) u_pick_b_urg (
        .mask (urgent_b), .start ('0), .found (urg_b_found), .idx (urg_b_idx)
    );

    wb_rr_picker #(.N(NUM_REQ)) u_pick_b_rr (
        .mask (mask_b), .start (rr_ptr_q), .found (rr_b_found), .idx (rr_b_idx)
    );

    assign b_found  = urg_b_found | rr_b_found;
    assign b_idx    = urg_b_found ? urg_b_idx : rr_b_idx;
    assign last_idx = b_found ? b_idx : a_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = rst_n && !bus.hold
                       && (drop[i]
                           || (a_found && (a_idx == IDX_W'(i)))
                           || (b_found && (b_idx == IDX_W'(i))));
        end
    end

    assign bus.req_ready = ready;
    assign bus.pending   = |(bus.req_valid & ~ready);

    // Unused ports keep their last addr/data so the register file sees no toggling.
    always_comb begin
        a_en_d   = 1'b0;
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        b_en_d   = 1'b0;
        b_addr_d = b_addr_q;
        b_data_d = b_data_q;
        rr_ptr_d = rr_ptr_q;
        if (!bus.hold && a_found) begin
            a_en_d   = 1'b1;
            a_addr_d = a_sel_addr;
            a_data_d = data_arr[a_idx];
            rr_ptr_d = IDX_W'(wrap_inc(int'(last_idx), NUM_REQ));
        end
        if (!bus.hold && b_found) begin
            b_en_d   = 1'b1;
            b_addr_d = addr_arr[b_idx];
            b_data_d = data_arr[b_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (!bus.hold) begin
                if (bus.req_valid[i] && !ready[i]) begin
                    wait_d[i] = (wait_q[i] == WAIT_SAT) ? wait_q[i] : wait_q[i] + 1'b1;
                end else begin
                    wait_d[i] = '0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            a_en_q   <= 1'b0;
            a_addr_q <= '0;
            a_data_q <= '0;
            b_en_q   <= 1'b0;
            b_addr_q <= '0;
            b_data_q <= '0;
            // NOTE: the counter array is small and its reset value is architectural,
            // so every entry is cleared rather than left as an unreset memory.
            for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            a_en_q   <= a_en_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            b_en_q   <= b_en_d;
            b_addr_q <= b_addr_d;
            b_data_q <= b_data_d;
            for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign bus.reg_a_wr_en   = a_en_q;
    assign bus.reg_a_wr_addr = a_addr_q;
    assign bus.reg_a_wr_data = a_data_q;
    assign bus.reg_b_wr_en   = b_en_q;
    assign bus.reg_b_wr_addr = b_addr_q;
    assign bus.reg_b_wr_data = b_data_q;

endmodule
